// File: rtl/vip_dehaze_pkg.sv
// Shared types and constants for the dark-channel dehaze stages.
// FSM state enum, histogram geometry, reset level and IIR mixer.
package vip_dehaze_pkg;

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    ACCUM,
    SCAN
  } atmos_state_e;

  localparam int          HIST_BINS   = 256;
  localparam int          CNT_W_DEF   = 20;
  localparam logic [19:0] TOP_NUM_DEF = 20'd480;
  localparam logic [7:0]  A_RESET     = 8'd255;

  // (3*old + new + 2) >> 2 ; worst case 1022 fits in 10 bits
  function automatic logic [7:0] iir_mix(
    input logic [7:0] a_old,
    input logic [7:0] a_new
  );
    logic [9:0] s;
    s = 10'd3 * {2'b00, a_old} + {2'b00, a_new} + 10'd2;
    return s[9:2];
  endfunction

endpackage

// File: rtl/vip_hist_ram_256x20.sv
// 256-entry histogram RAM: one write port, one registered read port.
// Ports: clk, we_i/waddr_i/wdata_i (write), raddr_i -> rdata_o (1 cycle).
module vip_hist_ram_256x20 #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         we_i,
  input  logic [7:0]   waddr_i,
  input  logic [W-1:0] wdata_i,
  input  logic [7:0]   raddr_i,
  output logic [W-1:0] rdata_o
);

  logic [W-1:0] mem_q [256];

  // A read colliding with a write returns the old word.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/vip_atmos_light_estimate.sv
// Atmospheric light estimate: per-frame 256-bin histogram of the
// dark-channel Y stream, scanned 255->0 at frame end to find A.
// Inputs: clk, rst_n, per_frame_vsync/href/clken, per_img_Y[7:0].
// Outputs: atmos_A[7:0], atmos_valid, busy, frame_skip.
// Build option ATMOS_IIR_EN: temporal smoothing of atmos_A.
module vip_atmos_light_estimate
  import vip_dehaze_pkg::*;
#(
  parameter logic [10:0]      IMG_HDISP = 11'd800,
  parameter logic [10:0]      IMG_VDISP = 11'd600,
  parameter int               CNT_W     = CNT_W_DEF,
  parameter logic [CNT_W-1:0] TOP_NUM   = TOP_NUM_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       per_frame_vsync,
  input  logic       per_frame_href,
  input  logic       per_frame_clken,
  input  logic [7:0] per_img_Y,
  output logic [7:0] atmos_A,
  output logic       atmos_valid,
  output logic       busy,
  output logic       frame_skip
);

  localparam longint FRAME_PIX =
    longint'(IMG_HDISP) * longint'(IMG_VDISP);

  if (FRAME_PIX > (longint'(1) << CNT_W) - 1) begin : g_cnt_w_chk
    $error("CNT_W too narrow for one frame");
  end

  atmos_state_e     state_q;
  logic [7:0]       clr_q;
  logic [8:0]       sc_q;
  logic             vs_q;
  logic             v1_q;
  logic [7:0]       a1_q;
  logic             fv_q;
  logic [7:0]       fa_q;
  logic [CNT_W-1:0] fd_q;
  logic             sv_q;
  logic [7:0]       sa_q;
  logic [CNT_W:0]   sum_q;
  logic             found_q;
  logic [7:0]       anew_q;
  logic             done_q;
  logic [7:0]       atmos_a_q;
  logic             valid_q;
  logic             busy_q;
  logic             skip_q;
`ifdef ATMOS_IIR_EN
  logic             iir_first_q;
`endif

  logic             vs_rise;
  logic             vs_fall;
  logic             pix_v;
  logic [CNT_W-1:0] rd;
  logic [CNT_W-1:0] cur;
  logic [CNT_W-1:0] inc;
  logic [CNT_W+1:0] sum_w;
  logic [CNT_W:0]   sum_d;
  logic             we;
  logic [7:0]       waddr;
  logic [CNT_W-1:0] wdata;
  logic [7:0]       raddr;

  assign vs_rise = per_frame_vsync & ~vs_q;
  assign vs_fall = ~per_frame_vsync & vs_q;
  assign pix_v   = (state_q == ACCUM) & per_frame_vsync
                 & per_frame_href & per_frame_clken;

  // RAM returned the pre-write word if the previous cycle
  // wrote this bin; take the value just written instead.
  assign cur = (fv_q && fa_q == a1_q) ? fd_q : rd;
  assign inc = (&cur) ? cur : cur + CNT_W'(1);

  assign sum_w = {1'b0, sum_q} + {2'b00, rd};
  assign sum_d = sum_w[CNT_W+1] ? '1 : sum_w[CNT_W:0];

  assign raddr = (state_q == SCAN) ? sc_q[7:0] : per_img_Y;

  always_comb begin
    we    = 1'b0;
    waddr = a1_q;
    wdata = inc;
    unique case (1'b1)
      v1_q: begin
        we    = 1'b1;
        waddr = a1_q;
        wdata = inc;
      end
      sv_q: begin
        we    = 1'b1;
        waddr = sa_q;
        wdata = '0;
      end
      (state_q == CLEAR): begin
        we    = 1'b1;
        waddr = clr_q;
        wdata = '0;
      end
      default: ;
    endcase
  end

  vip_hist_ram_256x20 #(
    .W (CNT_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr_i (raddr),
    .rdata_o (rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_q     <= '0;
      sc_q      <= '0;
      vs_q      <= 1'b0;
      v1_q      <= 1'b0;
      a1_q      <= '0;
      fv_q      <= 1'b0;
      fa_q      <= '0;
      fd_q      <= '0;
      sv_q      <= 1'b0;
      sa_q      <= '0;
      sum_q     <= '0;
      found_q   <= 1'b0;
      anew_q    <= '0;
      done_q    <= 1'b0;
      atmos_a_q <= A_RESET;
      valid_q   <= 1'b0;
      busy_q    <= 1'b1;
      skip_q    <= 1'b0;
`ifdef ATMOS_IIR_EN
      iir_first_q <= 1'b1;
`endif
    end else begin
      vs_q    <= per_frame_vsync;
      v1_q    <= pix_v;
      a1_q    <= per_img_Y;
      fv_q    <= v1_q;
      fa_q    <= a1_q;
      fd_q    <= inc;
      sv_q    <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      skip_q  <= vs_rise
               & (state_q == CLEAR | state_q == SCAN);

      if (sv_q) begin
        sum_q <= sum_d;
        if (!found_q && sum_d >= {1'b0, TOP_NUM}) begin
          found_q <= 1'b1;
          anew_q  <= sa_q;
        end
        if (sa_q == 8'd0) done_q <= 1'b1;
      end

      if (done_q) begin
        valid_q <= 1'b1;
`ifdef ATMOS_IIR_EN
        atmos_a_q <= iir_first_q ? anew_q
                   : iir_mix(atmos_a_q, anew_q);
        iir_first_q <= 1'b0;
`else
        atmos_a_q <= anew_q;
`endif
      end

      unique case (state_q)
        CLEAR: begin
          clr_q  <= clr_q + 8'd1;
          busy_q <= (clr_q != 8'hFF);
          if (clr_q == 8'hFF) state_q <= IDLE;
        end
        IDLE: begin
          busy_q <= 1'b0;
          if (vs_rise) state_q <= ACCUM;
        end
        ACCUM: begin
          busy_q <= vs_fall;
          if (vs_fall) begin
            state_q <= SCAN;
            sc_q    <= 9'h0FF;
            sum_q   <= '0;
            found_q <= 1'b0;
            anew_q  <= '0;
          end
        end
        SCAN: begin
          // sc_q[8] set once the read of bin 0 has been issued
          if (!sc_q[8]) begin
            sv_q <= 1'b1;
            sa_q <= sc_q[7:0];
            sc_q <= sc_q - 9'd1;
          end
          busy_q <= !(sv_q && sa_q == 8'd0);
          if (sv_q && sa_q == 8'd0) state_q <= IDLE;
        end
        default: begin
          state_q <= CLEAR;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign atmos_A     = atmos_a_q;
  assign atmos_valid = valid_q;
  assign busy        = busy_q;
  assign frame_skip  = skip_q;

endmodule

// File: tb/tb_vip_atmos_light_estimate.sv
// Bench for vip_atmos_light_estimate: frame-level histogram model
// checked every cycle, plus hand-computed A and latency values.
`timescale 1ns/1ps
module tb_vip_atmos_light_estimate;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vs = 1'b0;
  logic       href = 1'b0;
  logic       clken = 1'b0;
  logic [7:0] y = 8'd0;
  logic [7:0] atmos_A;
  logic       atmos_valid;
  logic       busy;
  logic       frame_skip;

  always #5 clk = ~clk;

  vip_atmos_light_estimate dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .per_frame_vsync (vs),
    .per_frame_href  (href),
    .per_frame_clken (clken),
    .per_img_Y       (y),
    .atmos_A         (atmos_A),
    .atmos_valid     (atmos_valid),
    .busy            (busy),
    .frame_skip      (frame_skip)
  );

`ifdef ATMOS_IIR_EN
  localparam int A2 = 200, A3 = 210, A4 = 190;
  localparam int A5A = 165, A5B = 139, A6B = 175;
`else
  localparam int A2 = 200, A3 = 240, A4 = 128;
  localparam int A5A = 90, A5B = 60, A6B = 100;
`endif

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string nm, input longint act,
                       input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // ---------------- frame-level model ----------------
  int         hist[256];
  int         m_mode;   // 0 clear, 1 idle, 2 frame, 3 scan
  int         m_left;
  bit         m_vs;
  bit         m_pend;
  bit         m_first;
  int         m_anew;
  logic [7:0] e_A;
  bit         e_valid, e_busy, e_skip;

  function automatic int estimate();
    int s = 0;
    int a = 0;
    bit f = 0;
    for (int b = 255; b >= 0; b--) begin
      s += hist[b];
      if (!f && s >= 480) begin
        f = 1;
        a = b;
      end
      hist[b] = 0;
    end
    return a;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_left = 256; m_vs = 0; m_pend = 0;
      m_first = 1; m_anew = 0;
      e_A = 8'd255; e_valid = 0; e_busy = 1; e_skip = 0;
      for (int i = 0; i < 256; i++) hist[i] = 0;
    end else begin : step
      bit rise, fall;
      rise = vs && !m_vs;
      fall = !vs && m_vs;
      m_vs = vs;
      e_skip = rise && (m_mode == 0 || m_mode == 3);
      e_valid = 0;
      if (m_pend) begin
        m_pend = 0;
        e_valid = 1;
`ifdef ATMOS_IIR_EN
        if (m_first) e_A = 8'(m_anew);
        else e_A = 8'((3 * int'(e_A) + m_anew + 2) / 4);
        m_first = 0;
`else
        e_A = 8'(m_anew);
`endif
      end
      case (m_mode)
        0: begin
          m_left--;
          if (m_left == 0) m_mode = 1;
        end
        1: if (rise) m_mode = 2;
        2: begin
          if (vs && href && clken) hist[y]++;
          if (fall) begin
            m_mode = 3;
            m_left = 257;
            m_anew = estimate();
          end
        end
        default: begin
          m_left--;
          if (m_left == 0) begin
            m_mode = 1;
            m_pend = 1;
          end
        end
      endcase
      e_busy = (m_mode == 0 || m_mode == 3);
    end
  end

  always @(posedge clk) begin
    #1;
    check("atmos_A", atmos_A, e_A);
    check("atmos_valid", atmos_valid, e_valid);
    check("busy", busy, e_busy);
    check("frame_skip", frame_skip, e_skip);
  end

  // ---------------- stimulus helpers ----------------
  task automatic px(input logic [7:0] v, input int n);
    repeat (n) begin
      @(negedge clk);
      href = 1; clken = 1; y = v;
    end
  endtask

  task automatic gap(input logic h, input logic c);
    @(negedge clk);
    href = h; clken = c; y = 8'd255;
  endtask

  task automatic frame_rise();
    @(negedge clk);
    vs = 1; href = 0; clken = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_clear(input string nm);
    int c = 0;
    do begin
      @(posedge clk); #1; c++;
    end while (busy && c < 400);
    check({nm, " clear cycles"}, c, 256);
  endtask

  task automatic bins_zero(input string nm);
    int nz = 0;
    for (int i = 0; i < 256; i++)
      if (dut.u_ram.mem_q[i] != 0) nz++;
    check({nm, " nonzero bins"}, nz, 0);
  endtask

  task automatic fall_and_wait(input string nm, input int exp_a);
    int lat = 0;
    bit got = 0;
    @(negedge clk);
    vs = 0; href = 0; clken = 0;
    @(posedge clk);
    for (int i = 0; i < 400 && !got; i++) begin
      @(posedge clk); #1; lat++;
      if (atmos_valid) got = 1;
    end
    check({nm, " latency"}, got ? lat : -1, 258);
    check({nm, " A"}, atmos_A, exp_a);
  endtask

  task automatic wait_valid(input string nm, input int exp_a);
    bit got = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(posedge clk); #1;
      if (atmos_valid) got = 1;
    end
    check({nm, " valid seen"}, got, 1);
    check({nm, " A"}, atmos_A, exp_a);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: reset and clear
    repeat (3) @(negedge clk);
    rst_n = 1;
    wait_clear("t1");
    check("t1 A", atmos_A, 255);
    bins_zero("t1");

    // 2: interleaved 200/50 with ungated gap cycles
    frame_rise();
    for (int i = 0; i < 480; i++) begin
      px(8'd200, 1);
      gap(1'b1, 1'b0);
      px(8'd50, 1);
      gap(1'b0, 1'b1);
    end
    px(8'd50, 500);
    fall_and_wait("t2", A2);

    // 3: long run of one value exercises forwarding
    frame_rise();
    px(8'd10, 300);
    px(8'd240, 1000);
    px(8'd10, 200);
    gap(1'b0, 1'b0);
    gap(1'b0, 1'b0);
    check("t3 bin240", dut.u_ram.mem_q[240], 1000);
    fall_and_wait("t3", A3);
    bins_zero("t3");

    // 4: threshold crossed exactly at bin 128
    frame_rise();
    px(8'd255, 479);
    px(8'd128, 1);
    px(8'd0, 40);
    fall_and_wait("t4", A4);

    // 5: frame starting inside SCAN is dropped
    frame_rise();
    px(8'd90, 480);
    px(8'd3, 50);
    @(negedge clk);
    vs = 0; href = 0; clken = 0;
    repeat (100) @(negedge clk);
    vs = 1;
    @(posedge clk); #1;
    check("t5 skip pulse", frame_skip, 1);
    px(8'd250, 100);
    @(negedge clk);
    vs = 0; href = 0; clken = 0;
    wait_valid("t5a", A5A);
    repeat (300) @(negedge clk);
    frame_rise();
    px(8'd60, 480);
    px(8'd5, 100);
    fall_and_wait("t5b", A5B);

    // 6: fresh reset, two frames, then reset mid-scan
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    wait_clear("t6");
    frame_rise();
    px(8'd200, 480);
    px(8'd0, 100);
    fall_and_wait("t6a", 200);
    frame_rise();
    px(8'd100, 480);
    px(8'd0, 100);
    fall_and_wait("t6b", A6B);
    frame_rise();
    px(8'd30, 600);
    @(negedge clk);
    vs = 0; href = 0; clken = 0;
    repeat (50) @(negedge clk);
    check("t6 busy in scan", busy, 1);
    rst_n = 0;
    #1;
    check("t6 A after reset", atmos_A, 255);
    check("t6 busy after reset", busy, 1);
    @(negedge clk);
    rst_n = 1;
    wait_clear("t6r");
    bins_zero("t6r");
    frame_rise();
    px(8'd77, 480);
    fall_and_wait("t6c", 77);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
